iter_shifter: RTL and testbench

//  Multi-cycle, parametrised shifter; the next generation of the single-bit Shifter32.

---
 rtl/iter_shifter.sv | 99 +++++++++
 tb/tb_iter_shifter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: captures an operand on Start, shifts up to STEP bits per
// clock in the captured mode, then registers the result and pulses Done for one cycle.
`timescale 1ns/1ps
module iter_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_input,
  input  logic [AW-1:0]    i_shift_amt,
  input  logic [1:0]       i_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_output
);

  typedef enum logic [1:0] {MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR} mode_e;
  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  localparam logic [AW-1:0] STEP_L  = AW'(STEP);
  localparam logic [AW:0]   WIDTH_L = (AW+1)'(WIDTH);

  state_e           r_state, w_next;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_work, r_out;
  logic [AW-1:0]    r_rem;
  logic             r_sign, r_done;

  logic             w_accept, w_last;
  logic [AW-1:0]    w_s;
  logic [AW:0]      w_rot;
  logic [WIDTH-1:0] w_fill, w_shift;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_rem <= STEP_L);
  assign w_s      = w_last ? r_rem : STEP_L;
  assign w_rot    = WIDTH_L - {1'b0, w_s};
  // ASR fills from the sign captured at Start, not from the current working value.
  assign w_fill   = r_sign ? ~({WIDTH{1'b1}} >> w_s) : '0;

  always_comb begin
    w_shift = r_work;
    case (r_mode)
      MODE_LSL: w_shift = r_work << w_s;
      MODE_LSR: w_shift = r_work >> w_s;
      MODE_ASR: w_shift = (r_work >> w_s) | w_fill;
      MODE_ROR: w_shift = (r_work >> w_s) | (r_work << w_rot);
      default:  w_shift = r_work;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE) begin
      if (i_start) w_next = S_SHIFT;
    end else begin
      if (w_last) w_next = S_IDLE;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_work <= '0;
      r_rem  <= '0;
      r_mode <= MODE_LSL;
      r_sign <= 1'b0;
      r_out  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_work <= i_input;
        r_rem  <= i_shift_amt;
        r_mode <= mode_e'(i_mode);
        r_sign <= i_input[WIDTH-1];
      end else if (r_state == S_SHIFT) begin
        r_work <= w_shift;
        r_rem  <= r_rem - w_s;
        if (w_last) begin
          r_out  <= w_shift;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy   = (r_state == S_SHIFT);
  assign o_done   = r_done;
  assign o_output = r_out;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: four instances (STEP 1,3,4,8) checked against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_iter_shifter;

  localparam int ND = 4;
  localparam int STEPS [ND] = '{1, 3, 4, 8};

  logic        clk = 1'b0;
  logic        rst;
  logic        start [ND];
  logic [31:0] din   [ND];
  logic [4:0]  amt_i [ND];
  logic [1:0]  mode  [ND];
  logic        busy  [ND];
  logic        done  [ND];
  logic [31:0] dout  [ND];
  logic [31:0] prev_out [ND];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    iter_shifter #(.WIDTH(32), .STEP(STEPS[g])) u_dut (
      .i_clock(clk), .i_reset(rst), .i_start(start[g]), .i_input(din[g]),
      .i_shift_amt(amt_i[g]), .i_mode(mode[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_output(dout[g])
    );
  end

  typedef struct {
    int          d;
    logic [31:0] a;
    int          amt;
    logic [1:0]  m;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic logic [31:0] ref_shift(logic [31:0] a, int amt, logic [1:0] m);
    case (m)
      2'd0:    return a << amt;
      2'd1:    return a >> amt;
      2'd2:    return 32'($signed(a) >>> amt);
      default: return (amt == 0) ? a : ((a >> amt) | (a << (32 - amt)));
    endcase
  endfunction

  function automatic int ref_lat(int amt, int s);
    return (amt == 0) ? 1 : (amt + s - 1) / s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one op on instance d and watch it to Done.
  task automatic do_op(input string name, input int d, input logic [31:0] a, input int amt,
                       input logic [1:0] m, input logic [31:0] exp, input int exp_lat);
    int lat, bcy;
    bit held;
    logic [31:0] res;
    held = 1'b1;
    @(negedge clk);
    start[d] = 1'b1; din[d] = a; amt_i[d] = 5'(amt); mode[d] = m;
    @(posedge clk); #1;
    start[d] = 1'b0; din[d] = $urandom; amt_i[d] = 5'($urandom); mode[d] = 2'($urandom);
    lat = 0; bcy = 0; res = 'x;
    while (lat < 200) begin
      if (busy[d]) bcy++;
      if (dout[d] !== prev_out[d]) held = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done[d]) begin res = dout[d]; break; end
    end
    if (lat >= 200) chk({name, "_timeout"}, 32'(lat), 32'(exp_lat));
    chk({name, "_result"}, res, exp);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(bcy), 32'(exp_lat));
    chk({name, "_output_held"}, 32'(held), 32'd1);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 32'(done[d]), 32'd0);
    prev_out[d] = exp;
  endtask

  initial begin
    vec_t vecs [$];
    int nd, lat;
    logic [31:0] res, a;
    int amt;
    logic [1:0] m;

    for (int i = 0; i < ND; i++) begin
      start[i] = 1'b0; din[i] = '0; amt_i[i] = '0; mode[i] = '0; prev_out[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("reset_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("reset_done%0d", i), 32'(done[i]), 32'd0);
      chk($sformatf("reset_out%0d", i), dout[i], 32'd0);
    end

    // d: 0=S1, 1=S3, 2=S4, 3=S8
    vecs.push_back('{0, 32'h80000001, 1,  2'd0, 32'h00000002, 1});
    vecs.push_back('{0, 32'h80000001, 1,  2'd1, 32'h40000000, 1});
    vecs.push_back('{0, 32'h80000000, 4,  2'd2, 32'hF8000000, 4});
    vecs.push_back('{2, 32'h00000001, 31, 2'd3, 32'h00000002, 8});
    vecs.push_back('{0, 32'h12345678, 0,  2'd0, 32'h12345678, 1});
    vecs.push_back('{0, 32'h12345678, 0,  2'd1, 32'h12345678, 1});
    vecs.push_back('{0, 32'h12345678, 0,  2'd2, 32'h12345678, 1});
    vecs.push_back('{3, 32'h12345678, 0,  2'd3, 32'h12345678, 1});
    vecs.push_back('{1, 32'h80000000, 7,  2'd2, 32'hFF000000, 3});
    vecs.push_back('{3, 32'h0000FF00, 8,  2'd3, 32'h000000FF, 1});
    vecs.push_back('{2, 32'h7FFFFFFF, 31, 2'd2, 32'h00000000, 8});
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, vecs[i].amt, vecs[i].m,
            vecs[i].exp, vecs[i].lat);

    // Start pulses while busy are dropped.
    @(negedge clk);
    start[0] = 1'b1; din[0] = 32'h80000000; amt_i[0] = 5'd8; mode[0] = 2'd2;
    @(posedge clk); #1;
    start[0] = 1'b0;
    nd = 0; res = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done[0]) begin nd++; res = dout[0]; end
      if (i == 2 || i == 4) begin
        start[0] = 1'b1; din[0] = 32'h0000FFFF; amt_i[0] = 5'd1; mode[0] = 2'd0;
      end else begin
        start[0] = 1'b0;
      end
    end
    chk("ignore_busy_done_count", 32'(nd), 32'd1);
    chk("ignore_busy_result", res, 32'hFF800000);
    prev_out[0] = 32'hFF800000;

    // Start held high across Done: second op accepted with no bubble.
    @(negedge clk);
    start[0] = 1'b1; din[0] = 32'h00000001; amt_i[0] = 5'd3; mode[0] = 2'd0;
    @(posedge clk); #1;
    din[0] = 32'h0000000F; amt_i[0] = 5'd2; mode[0] = 2'd0;
    lat = 0;
    while (lat < 50 && !done[0]) begin @(posedge clk); #1; lat++; end
    chk("b2b_first_latency", 32'(lat), 32'd3);
    chk("b2b_first_result", dout[0], 32'h00000008);
    @(posedge clk); #1;
    chk("b2b_no_bubble_busy", 32'(busy[0]), 32'd1);
    start[0] = 1'b0;
    lat = 0;
    while (lat < 50 && !done[0]) begin @(posedge clk); #1; lat++; end
    chk("b2b_second_latency", 32'(lat), 32'd2);
    chk("b2b_second_result", dout[0], 32'h0000003C);
    prev_out[0] = 32'h0000003C;

    // Reset mid-operation aborts.
    @(negedge clk);
    start[0] = 1'b1; din[0] = 32'h80000000; amt_i[0] = 5'd8; mode[0] = 2'd2;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy[0]), 32'd0);
    chk("midreset_done", 32'(done[0]), 32'd0);
    chk("midreset_out", dout[0], 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < ND; i++) prev_out[i] = '0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (done[0]) nd++; end
    chk("midreset_no_done", 32'(nd), 32'd0);
    do_op("after_reset", 0, 32'h0000FF00, 8, 2'd1, 32'h000000FF, 8);

    // Random regression against the arithmetic model.
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 30; i++) begin
        a   = $urandom;
        amt = $urandom_range(0, 31);
        m   = 2'($urandom_range(0, 3));
        do_op($sformatf("rnd_s%0d_%0d", STEPS[d], i), d, a, amt, m,
              ref_shift(a, amt, m), ref_lat(amt, STEPS[d]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
